// File: rtl/dmem_copy_engine.sv
// Word-by-word block copy engine sharing the data-memory port through an arbiter grant.
// Optional XOR checksum of written words is enabled by defining DMEM_COPY_CHECKSUM_EN.
module dmem_copy_engine #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              mem_gnt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    output logic [31:0]       csum
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;
    logic [31:0]       data_q;

    // busy/done are registered alongside the state so they track it exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            data_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        count   <= len;
                        err     <= 1'b0;
                        if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                            err <= 1'b1;
                        end else if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (mem_gnt) begin
                        data_q <= mem_rdata;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (mem_gnt) begin
                        src_ptr <= src_ptr + ADDR_W'(4);
                        dst_ptr <= dst_ptr + ADDR_W'(4);
                        count   <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_COPY_CHECKSUM_EN
    // A granted write lands in memory even during abort, so it is folded in too
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum <= '0;
        end else if ((state == IDLE) && start) begin
            csum <= '0;
        end else if ((state == WRITE) && mem_gnt) begin
            csum <= csum ^ data_q;
        end
    end
`endif

    always_comb begin
        mem_addr = '0;
        case (state)
            READ:    mem_addr = src_ptr;
            WRITE:   mem_addr = dst_ptr;
            default: mem_addr = '0;
        endcase
    end

    // Write strobe gated by reset so a reset cycle never corrupts memory
    assign mem_we    = (state == WRITE) && mem_gnt && rst_n;
    assign mem_req   = busy;
    assign mem_wdata = data_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: 64-word memory, per-cycle reference model,
// directed corner cases and randomized copies with random grants, aborts and restarts.
module tb_dmem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_gnt;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [31:0] csum;
`endif

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] ld_img  [0:63];
    logic        ld_en;

    int n_checks = 0;
    int n_pass   = 0;

    bit          m_valid  = 1'b0;
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_err    = 1'b0;
    int          m_grants = 0;
    int          m_total  = 0;
    logic [31:0] m_src    = '0;
    logic [31:0] m_dst    = '0;
    logic [31:0] m_csum   = '0;

    always #5 clk = ~clk;

    dmem_copy_engine #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_gnt   (mem_gnt),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_COPY_CHECKSUM_EN
        ,
        .csum      (csum)
`endif
    );

    // Memory aliases every address onto 64 words; reads are combinational
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= ld_img[i];
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: a copy is 2*len granted accesses, alternating read/write per word
    always @(negedge clk) begin
        int          k;
        bit          ph;
        bit          ewe;
        logic [31:0] es;
        logic [31:0] ed;
        k   = m_grants / 2;
        ph  = (m_grants % 2) == 1;
        es  = m_src + 32'(4 * k);
        ed  = m_dst + 32'(4 * k);
        ewe = m_active && ph && mem_gnt && rst_n;
        if (m_valid) begin
            checkOutput("busy", 32'(busy), 32'(m_active));
            checkOutput("mem_req", 32'(mem_req), 32'(m_active));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("err", 32'(err), 32'(m_err));
            checkOutput("mem_we", 32'(mem_we), 32'(ewe));
            if (m_active) checkOutput("mem_addr", mem_addr, ph ? ed : es);
            else if (!m_done) checkOutput("mem_addr_idle", mem_addr, 32'h0);
            if (ewe) checkOutput("mem_wdata", mem_wdata, ref_mem[es[7:2]]);
`ifdef DMEM_COPY_CHECKSUM_EN
            checkOutput("csum", csum, m_csum);
`endif
        end
        if (ld_en) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = ld_img[i];
        end
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_csum   = '0;
        end else if (m_valid) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_active) begin
                if (mem_gnt && ph) begin
                    ref_mem[ed[7:2]] = ref_mem[es[7:2]];
                    m_csum = m_csum ^ ref_mem[es[7:2]];
                end
                if (abort) begin
                    m_active = 1'b0;
                end else if (mem_gnt) begin
                    m_grants++;
                    if (m_grants == m_total) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (start) begin
                m_err  = 1'b0;
                m_csum = '0;
                if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                    m_err = 1'b1;
                end else if (len == 16'd0) begin
                    m_done = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_total  = 2 * int'(len);
                    m_grants = 0;
                    m_src    = src_addr;
                    m_dst    = dst_addr;
                end
            end
        end
    end

    task automatic loadMem(input bit rnd);
        for (int i = 0; i < 64; i++) ld_img[i] = rnd ? $urandom : 32'h0;
        if (!rnd) begin
            ld_img[0] = 32'h11111111;
            ld_img[1] = 32'h22222222;
            ld_img[2] = 32'h33333333;
            ld_img[3] = 32'h44444444;
        end
        ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic checkMem();
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        checkOutput("mem_image_bad_words", 32'(bad), 32'h0);
    endtask

    task automatic randInputs();
        src_addr = 32'($urandom_range(0, 15)) << 2;
        dst_addr = 32'($urandom_range(32, 47)) << 2;
        len      = 16'($urandom_range(0, 8));
        if ($urandom_range(0, 7) == 0) src_addr[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) dst_addr[1:0] = 2'($urandom_range(1, 3));
    endtask

    // mode 0: grant tied high, 1: grant high on even cycles, 2: random grant and spurious starts
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                                 input int mode, input int abort_cyc, input int rst_cyc, input int ncyc,
                                 output int done_cyc, output int busy_cnt, output int we_cnt);
        done_cyc = -1;
        busy_cnt = 0;
        we_cnt   = 0;
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        abort    = 1'b0;
        rst_n    = 1'b1;
        mem_gnt  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (mode == 2) begin
                randInputs();
                start = ($urandom_range(0, 7) == 0);
            end else begin
                src_addr = $urandom;
                dst_addr = $urandom;
                len      = 16'($urandom);
            end
            case (mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = ((k % 2) == 0);
                default: mem_gnt = 1'($urandom_range(0, 1));
            endcase
            abort = (k == abort_cyc);
            rst_n = (k != rst_cyc);
            @(negedge clk);
            if (done && done_cyc < 0) done_cyc = k;
            if (busy) busy_cnt++;
            if (mem_we) we_cnt++;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        abort   = 1'b0;
        rst_n   = 1'b1;
        mem_gnt = 1'b1;
        repeat (24) @(posedge clk);
        #1;
    endtask

    initial begin
        int dc, bc, wc;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        mem_gnt  = 1'b0;
        ld_en    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        checkOutput("reset_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        loadMem(1'b0);
        applyStimulus(32'h0, 32'h40, 16'd4, 0, 0, 0, 12, dc, bc, wc);
        checkOutput("basic_done_cycle", 32'(dc), 32'd9);
        checkOutput("basic_busy_cycles", 32'(bc), 32'd8);
        checkOutput("basic_word0", mem[16], 32'h11111111);
        checkOutput("basic_word3", mem[19], 32'h44444444);
`ifdef DMEM_COPY_CHECKSUM_EN
        checkOutput("basic_csum", csum, 32'h44444444);
`endif
        checkMem();

        loadMem(1'b0);
        applyStimulus(32'h0, 32'h40, 16'd4, 1, 0, 0, 24, dc, bc, wc);
        checkOutput("stall_done_cycle", 32'(dc), 32'd17);
        checkOutput("stall_writes", 32'(wc), 32'd4);
        checkOutput("stall_word2", mem[18], 32'h33333333);
        checkMem();

        applyStimulus(32'h0, 32'h80, 16'd0, 0, 0, 0, 4, dc, bc, wc);
        checkOutput("len0_done_cycle", 32'(dc), 32'd1);
        checkOutput("len0_busy_cycles", 32'(bc), 32'd0);

        applyStimulus(32'h2, 32'h80, 16'd4, 0, 0, 0, 6, dc, bc, wc);
        checkOutput("misalign_err", 32'(err), 32'h1);
        checkOutput("misalign_done", 32'(dc), 32'hFFFFFFFF);
        checkOutput("misalign_writes", 32'(wc), 32'd0);
        applyStimulus(32'h0, 32'h80, 16'd1, 0, 0, 0, 4, dc, bc, wc);
        checkOutput("err_cleared", 32'(err), 32'h0);
        checkOutput("recover_word", mem[32], 32'h11111111);

        loadMem(1'b0);
        applyStimulus(32'h0, 32'h40, 16'd8, 0, 6, 0, 12, dc, bc, wc);
        checkOutput("abort_writes", 32'(wc), 32'd3);
        checkOutput("abort_done", 32'(dc), 32'hFFFFFFFF);
        checkMem();

        loadMem(1'b0);
        applyStimulus(32'h0, 32'h40, 16'd4, 0, 0, 4, 10, dc, bc, wc);
        checkOutput("reset_mid_writes", 32'(wc), 32'd1);
        checkOutput("reset_mid_word0", mem[16], 32'h11111111);
        checkOutput("reset_mid_word1", mem[17], 32'h0);
        checkOutput("reset_mid_done", 32'(dc), 32'hFFFFFFFF);

        loadMem(1'b1);
        applyStimulus(32'hFFFFFFF8, 32'h80, 16'd4, 0, 0, 0, 10, dc, bc, wc);
        checkOutput("wrap_word0", mem[32], ld_img[62]);
        checkOutput("wrap_word2", mem[34], ld_img[0]);
        checkMem();

        for (int t = 0; t < 25; t++) begin
            int      ab;
            logic [31:0] rs, rd;
            logic [15:0] rl;
            loadMem(1'b1);
            rs = 32'($urandom_range(0, 15)) << 2;
            rd = 32'($urandom_range(32, 47)) << 2;
            rl = 16'($urandom_range(0, 8));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            applyStimulus(rs, rd, rl, 2, ab, 0, 60, dc, bc, wc);
            checkMem();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
- Memory-side initiator: drives the same addr/we/wdata/rdata word interface the data memory responds on.
- Copies a block of 32-bit words from a source region to a destination region.
- Runs one word at a time: read, then write, one port access per cycle.
- Sits beside the core on the data-memory port; an external arbiter grants it access cycle by cycle via mem_gnt.

Parameters:
- ADDR_W, 32, width of byte addresses on the memory interface and of the src/dst configuration inputs.
- LEN_W, 16, width of the word-count input and of the internal remaining-count register.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  one-cycle request to begin a copy; sampled only in IDLE
- abort  input  1  cancel in-progress copy
- src_addr  input  ADDR_W  source byte address, captured on accepted start
- dst_addr  input  ADDR_W  destination byte address, captured on accepted start
- len  input  LEN_W  number of words, captured on accepted start
- busy  output  1  high in READ/WRITE states
- done  output  1  one-cycle pulse on successful completion
- err  output  1  sticky misalignment flag, cleared by next accepted start
- mem_gnt  input  1  arbiter grant; the engine's access completes only in granted cycles
- mem_req  output  1  engine wants the port this cycle (= busy)
- mem_addr  output  ADDR_W  byte address to memory
- mem_we  output  1  write enable to memory
- mem_wdata  output  32  write data to memory
- mem_rdata  input  32  combinational read data from memory for mem_addr

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Memory model: combinational read, write on rising clk when mem_we=1.
- Reset (rst_n=0 at an edge): state=IDLE; src_ptr, dst_ptr, count and data_q cleared; busy=0, done=0, err=0.
- Reset, same cycle: mem_we is forced 0 combinationally while rst_n=0, whatever the current state.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem_req=0, mem_we=0, mem_addr=0.
  - On start=1: capture src/dst/len and clear err.
  - If src_addr[1:0] or dst_addr[1:0] is nonzero: set err=1, stay IDLE.
  - Else if len=0: go DONE.
  - Else: go READ.
- READ:
  - mem_addr=src_ptr, mem_we=0.
  - If mem_gnt=1: latch data_q<=mem_rdata, go WRITE.
  - Else: hold state.
- WRITE:
  - mem_addr=dst_ptr, mem_wdata=data_q, mem_we=mem_gnt & rst_n.
  - If mem_gnt=1: src_ptr+=4, dst_ptr+=4, count-=1. Go DONE if count was 1, else READ.
  - Else: hold state.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency with mem_gnt tied high: N words take 2N busy cycles plus 1 done cycle; done is high in cycle 2N+1 after the start edge.
- start while not IDLE is ignored; input changes after capture are ignored.
- abort=1 in READ or WRITE: next edge goes to IDLE with no done pulse.
  - mem_we stays combinational in the abort cycle, so a granted write in that cycle still completes.
  - abort in IDLE or DONE has no effect; done still pulses.
- Pointers wrap modulo 2^ADDR_W; no bounds check.
- Overlapping regions: copied in ascending address order. Forward overlap (dst>src) is undefined by design.
- err stays set until the next accepted start or reset.

Optional Feature:
- Macro: DMEM_COPY_CHECKSUM_EN.
- When defined:
  - Adds output csum[31:0], a 32-bit XOR of every word written.
  - csum is cleared on accepted start and on reset.
  - csum updates on each granted WRITE and is stable while done is high.
- When undefined: csum port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic copy: memory words 0x00..0x0C preloaded 0x11111111, 0x22222222, 0x33333333, 0x44444444; src=0x00, dst=0x40, len=4, gnt=1 -> words 0x40..0x4C hold those values, done pulses 9 cycles after start, busy high for 8 cycles.
- Stalls: same copy with mem_gnt toggling 1,0,1,0 -> same memory result, no write issued in any gnt=0 cycle, done delayed to cycle 17.
- Corner inputs:
  - len=0 -> done pulses in the next cycle, no memory access.
  - src=0x02 -> err=1, no access, no done; a later valid start clears err.
- Abort: len=8, abort asserted in the 3rd WRITE -> exactly 3 words written, IDLE next cycle, done never asserts.
- Reset mid-copy: rst_n=0 during a WRITE cycle -> mem_we=0 in that cycle, all outputs 0 after the edge, destination word unchanged.
- Checksum (with DMEM_COPY_CHECKSUM_EN): basic copy -> csum=0x11111111^0x22222222^0x33333333^0x44444444=0x44444444 at done.
